// File: rtl/me_sad_engine.sv
// me_sad_engine: N_PE x N_STEP block-match SAD search with an internal running minimum.
// Optional macro ME_ZMV_BIAS_EN biases the centre candidate (dx=N_PE/2, dy=N_STEP/2) by ZMV_BIAS.
module me_sad_engine #(
  parameter int PIX_W = 8,
  parameter int BLK = 4,
  parameter int N_PE = 8,
  parameter int N_STEP = 8,
  parameter int SAD_W = 21,
  parameter int ZMV_BIAS = 16,
  localparam int VEC_W = $clog2((N_PE > N_STEP) ? N_PE : N_STEP) + 1
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [BLK*PIX_W-1:0]          cur_row,
  input  logic                          cur_valid,
  output logic                          cur_ready,
  input  logic [(BLK+N_PE-1)*PIX_W-1:0] can_row,
  input  logic                          can_valid,
  output logic                          can_ready,
  output logic                          vec_valid,
  input  logic                          vec_ready,
  output logic [VEC_W-1:0]              vec_x,
  output logic [VEC_W-1:0]              vec_y,
  output logic [SAD_W-1:0]              best_sad,
  output logic                          busy
);
  localparam int RW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int XW = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int SW = (N_STEP > 1) ? $clog2(N_STEP) : 1;
  localparam int EW = ((SAD_W > PIX_W + $clog2(BLK)) ? SAD_W : PIX_W + $clog2(BLK)) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_CUR, SEARCH, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [BLK*PIX_W-1:0] cur_q [BLK];
  logic [BLK*PIX_W-1:0] cur_d [BLK];
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] step_q, step_d;
  logic [1:0] fl_q, fl_d;
  logic [SAD_W-1:0] acc_q [N_PE];
  logic [SAD_W-1:0] acc_d [N_PE];
  logic [SAD_W-1:0] cmp_q [N_PE];
  logic [SAD_W-1:0] cmp_d [N_PE];
  logic cmp_v_q, cmp_v_d;
  logic [SW-1:0] cmp_dy_q, cmp_dy_d;
  logic [SAD_W-1:0] best_key_q, best_key_d;
  logic [XW-1:0] best_dx_q, best_dx_d;
  logic [SW-1:0] best_dy_q, best_dy_d;
  logic vec_valid_q, vec_valid_d;
  logic [VEC_W-1:0] vec_x_q, vec_x_d, vec_y_q, vec_y_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [EW-1:0] rs [N_PE];
  logic [EW-1:0] sum [N_PE];
  logic [SAD_W-1:0] sat [N_PE];
  logic [SAD_W-1:0] key [N_PE];
  logic [SAD_W-1:0] mkey, mraw;
  logic [XW-1:0] mdx;
`ifdef ME_ZMV_BIAS_EN
  logic [SAD_W-1:0] best_raw_q, best_raw_d;
`endif

  function automatic logic [PIX_W-1:0] ad(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  assign cur_ready = state_q == LOAD_CUR;
  assign can_ready = state_q == SEARCH;
  assign busy = state_q != IDLE;
  assign vec_valid = vec_valid_q;
  assign vec_x = vec_x_q;
  assign vec_y = vec_y_q;
  assign best_sad = best_sad_q;

  // Row SAD per PE added to the running sum; clamps to all-ones if SAD_W is undersized.
  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      rs[p] = '0;
      for (int i = 0; i < BLK; i++)
        rs[p] = rs[p] + EW'(ad(cur_q[row_q][i*PIX_W +: PIX_W], can_row[(p+i)*PIX_W +: PIX_W]));
      sum[p] = EW'(acc_q[p]) + rs[p];
      sat[p] = (|sum[p][EW-1:SAD_W]) ? '1 : sum[p][SAD_W-1:0];
    end
  end

  // Min scan over the completed step; strict less keeps the lowest dx on ties.
  always_comb begin
    for (int p = 0; p < N_PE; p++) key[p] = cmp_q[p];
`ifdef ME_ZMV_BIAS_EN
    if (cmp_dy_q == SW'(N_STEP/2))
      key[N_PE/2] = (cmp_q[N_PE/2] > SAD_W'(ZMV_BIAS)) ? cmp_q[N_PE/2] - SAD_W'(ZMV_BIAS) : '0;
`endif
    mkey = key[0];
    mraw = cmp_q[0];
    mdx = '0;
    for (int p = 1; p < N_PE; p++)
      if (key[p] < mkey) begin
        mkey = key[p];
        mraw = cmp_q[p];
        mdx = XW'(p);
      end
  end

  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    row_d = row_q;
    step_d = step_q;
    fl_d = fl_q;
    acc_d = acc_q;
    cmp_d = cmp_q;
    cmp_v_d = 1'b0;
    cmp_dy_d = cmp_dy_q;
    best_key_d = best_key_q;
    best_dx_d = best_dx_q;
    best_dy_d = best_dy_q;
`ifdef ME_ZMV_BIAS_EN
    best_raw_d = best_raw_q;
`endif
    vec_valid_d = vec_valid_q;
    vec_x_d = vec_x_q;
    vec_y_d = vec_y_q;
    best_sad_d = best_sad_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD_CUR;
        row_d = '0;
      end
      LOAD_CUR: if (cur_valid) begin
        cur_d[row_q] = cur_row;
        row_d = (row_q == RW'(BLK-1)) ? '0 : row_q + 1'b1;
        state_d = (row_q == RW'(BLK-1)) ? SEARCH : LOAD_CUR;
        step_d = '0;
      end
      SEARCH: if (can_valid) begin
        if (row_q == RW'(BLK-1)) begin
          row_d = '0;
          cmp_d = sat;
          cmp_v_d = 1'b1;
          cmp_dy_d = step_q;
          for (int p = 0; p < N_PE; p++) acc_d[p] = '0;
          step_d = step_q + 1'b1;
          state_d = (step_q == SW'(N_STEP-1)) ? FLUSH : SEARCH;
          fl_d = '0;
        end else begin
          row_d = row_q + 1'b1;
          acc_d = sat;
        end
      end
      FLUSH: begin
        fl_d = fl_q + 2'd1;
        if (fl_q == 2'd2) begin
          state_d = DONE;
          vec_valid_d = 1'b1;
          vec_x_d = VEC_W'(best_dx_q) - VEC_W'(N_PE/2);
          vec_y_d = VEC_W'(best_dy_q) - VEC_W'(N_STEP/2);
`ifdef ME_ZMV_BIAS_EN
          best_sad_d = best_raw_q;
`else
          best_sad_d = best_key_q;
`endif
        end
      end
      DONE: if (vec_ready) begin
        state_d = IDLE;
        vec_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // The first step of a search (dy=0) always seeds best.
    if (cmp_v_q && (cmp_dy_q == '0 || mkey < best_key_q)) begin
      best_key_d = mkey;
      best_dx_d = mdx;
      best_dy_d = cmp_dy_q;
`ifdef ME_ZMV_BIAS_EN
      best_raw_d = mraw;
`endif
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      for (int r = 0; r < BLK; r++) cur_q[r] <= '0;
      row_q <= '0;
      step_q <= '0;
      fl_q <= '0;
      for (int p = 0; p < N_PE; p++) begin
        acc_q[p] <= '0;
        cmp_q[p] <= '0;
      end
      cmp_v_q <= 1'b0;
      cmp_dy_q <= '0;
      best_key_q <= '0;
      best_dx_q <= '0;
      best_dy_q <= '0;
`ifdef ME_ZMV_BIAS_EN
      best_raw_q <= '0;
`endif
      vec_valid_q <= 1'b0;
      vec_x_q <= '0;
      vec_y_q <= '0;
      best_sad_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      row_q <= row_d;
      step_q <= step_d;
      fl_q <= fl_d;
      acc_q <= acc_d;
      cmp_q <= cmp_d;
      cmp_v_q <= cmp_v_d;
      cmp_dy_q <= cmp_dy_d;
      best_key_q <= best_key_d;
      best_dx_q <= best_dx_d;
      best_dy_q <= best_dy_d;
`ifdef ME_ZMV_BIAS_EN
      best_raw_q <= best_raw_d;
`endif
      vec_valid_q <= vec_valid_d;
      vec_x_q <= vec_x_d;
      vec_y_q <= vec_y_d;
      best_sad_q <= best_sad_d;
    end
  end
endmodule

// File: tb/tb_me_sad_engine.sv
// tb_me_sad_engine: randomized scoreboard bench for me_sad_engine against a plain-arithmetic search model.
module tb_me_sad_engine;
  localparam int PIX_W = 8, BLK = 4, N_PE = 8, N_STEP = 8, SAD_W = 21, ZMV_BIAS = 16;
  localparam int VEC_W = 4, CW = BLK + N_PE - 1;
  logic CLK = 0, resetn = 0, start = 0, cur_valid = 0, can_valid = 0, vec_ready = 0;
  logic [BLK*PIX_W-1:0] cur_row = '0;
  logic [CW*PIX_W-1:0] can_row = '0;
  logic cur_ready, can_ready, vec_valid, busy;
  logic [VEC_W-1:0] vec_x, vec_y;
  logic [SAD_W-1:0] best_sad;
  int checks = 0, errors = 0;
  typedef struct {int x; int y; int sad;} exp_t;
  exp_t expq[$];
  int cur_m [BLK][BLK];
  int can_m [N_STEP][BLK][CW];

  always #5 CLK = ~CLK;

  me_sad_engine #(.PIX_W(PIX_W), .BLK(BLK), .N_PE(N_PE), .N_STEP(N_STEP), .SAD_W(SAD_W), .ZMV_BIAS(ZMV_BIAS)) dut (
    .CLK(CLK), .resetn(resetn), .start(start), .cur_row(cur_row), .cur_valid(cur_valid), .cur_ready(cur_ready),
    .can_row(can_row), .can_valid(can_valid), .can_ready(can_ready), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_x(vec_x), .vec_y(vec_y), .best_sad(best_sad), .busy(busy));

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Exhaustive search in raster order (dy, then dx); strict less keeps the earliest on ties.
  function automatic exp_t model();
    exp_t e;
    int bk, k, s, d;
    bk = -1;
    e = '{0, 0, 0};
    for (int dy = 0; dy < N_STEP; dy++)
      for (int dx = 0; dx < N_PE; dx++) begin
        s = 0;
        for (int r = 0; r < BLK; r++)
          for (int i = 0; i < BLK; i++) begin
            d = cur_m[r][i] - can_m[dy][r][dx+i];
            s += (d < 0) ? -d : d;
          end
        k = s;
`ifdef ME_ZMV_BIAS_EN
        if (dx == N_PE/2 && dy == N_STEP/2) k = (s > ZMV_BIAS) ? s - ZMV_BIAS : 0;
`endif
        if (bk < 0 || k < bk) begin
          bk = k;
          e.x = dx - N_PE/2;
          e.y = dy - N_STEP/2;
          e.sad = s;
        end
      end
    return e;
  endfunction

  always @(negedge CLK) begin
    if (vec_valid && vec_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("vec_x", int'($signed(vec_x)), e.x);
        chk("vec_y", int'($signed(vec_y)), e.y);
        chk("best_sad", int'(best_sad), e.sad);
      end
    end
  end

  task automatic idle(input int stall);
    int n;
    n = (stall > 0) ? $urandom_range(0, stall) : 0;
    repeat (n) begin
      cur_row = $urandom;
      can_row = (CW*PIX_W)'({$urandom, $urandom, $urandom});
      @(posedge CLK); #1;
    end
  endtask

  task automatic beat_cur(input int r);
    int n;
    n = 0;
    for (int i = 0; i < BLK; i++) cur_row[i*PIX_W +: PIX_W] = PIX_W'(cur_m[r][i]);
    cur_valid = 1;
    while (!cur_ready && n < 20) begin @(posedge CLK); #1; n++; end
    if (!cur_ready) chk("cur_ready_timeout", 0, 1);
    @(posedge CLK); #1;
    cur_valid = 0;
    cur_row = $urandom;
  endtask

  task automatic beat_can(input int dy, input int r);
    int n;
    n = 0;
    for (int j = 0; j < CW; j++) can_row[j*PIX_W +: PIX_W] = PIX_W'(can_m[dy][r][j]);
    can_valid = 1;
    while (!can_ready && n < 20) begin @(posedge CLK); #1; n++; end
    if (!can_ready) chk("can_ready_timeout", 0, 1);
    @(posedge CLK); #1;
    can_valid = 0;
    can_row = (CW*PIX_W)'({$urandom, $urandom, $urandom});
  endtask

  task automatic do_search(input int stall, input bit hold);
    exp_t e;
    int n;
    e = model();
    expq.push_back(e);
    start = 1;
    @(posedge CLK); #1;
    start = 0;
    for (int r = 0; r < BLK; r++) begin idle(stall); beat_cur(r); end
    for (int k = 0; k < N_STEP*BLK; k++) begin idle(stall); beat_can(k / BLK, k % BLK); end
    n = 0;
    while (!vec_valid && n < 10) begin @(posedge CLK); #1; n++; end
    chk("latency", n, 3);
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        start = (c == 2);
        chk("hold_valid", int'(vec_valid), 1);
        chk("hold_x", int'($signed(vec_x)), e.x);
        chk("hold_sad", int'(best_sad), e.sad);
        @(posedge CLK); #1;
      end
      start = 0;
      chk("hold_after_start", int'(vec_valid), 1);
    end
    vec_ready = 1;
    @(posedge CLK); #1;
    vec_ready = 0;
    chk("busy_after_accept", int'(busy), 0);
    chk("valid_after_accept", int'(vec_valid), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_vec_valid", int'(vec_valid), 0);
    chk("rst_vec_x", int'(vec_x), 0);
    chk("rst_vec_y", int'(vec_y), 0);
    chk("rst_best_sad", int'(best_sad), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur_ready", int'(cur_ready), 0);
    chk("rst_can_ready", int'(can_ready), 0);
  endtask

  task automatic fill_const(input int cv, input int kv);
    foreach (cur_m[r, i]) cur_m[r][i] = cv;
    foreach (can_m[d, r, j]) can_m[d][r][j] = kv;
  endtask

  task automatic fill_rand();
    foreach (cur_m[r, i]) cur_m[r][i] = $urandom_range(0, 255);
    foreach (can_m[d, r, j]) can_m[d][r][j] = $urandom_range(0, 255);
  endtask

  initial begin
    int v;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs();
    resetn = 1;
    @(posedge CLK); #1;
    // Exact match only at dx=3, dy=5.
    v = $urandom_range(0, 200);
    fill_const(v, v + 10);
    for (int r = 0; r < BLK; r++) for (int i = 0; i < BLK; i++) can_m[5][r][3+i] = v;
    do_search(0, 0);
    // Every candidate equally off: tie resolves to the first one.
    foreach (cur_m[r, i]) cur_m[r][i] = 0;
    for (int r = 0; r < BLK; r++) begin
      v = $urandom_range(0, 245);
      for (int i = 0; i < BLK; i++) cur_m[r][i] = v;
      for (int d = 0; d < N_STEP; d++) for (int j = 0; j < CW; j++) can_m[d][r][j] = v + 10;
    end
    do_search(0, 0);
    fill_const(0, 255);
    do_search(0, 0);
    do_search(3, 0);
    fill_rand();
    do_search(2, 1);
    // Abort mid-search with reset; nothing is expected from the aborted run.
    fill_rand();
    start = 1;
    @(posedge CLK); #1;
    start = 0;
    for (int r = 0; r < BLK; r++) beat_cur(r);
    for (int k = 0; k < 10; k++) beat_can(k / BLK, k % BLK);
    resetn = 0;
    #2;
    check_reset_outputs();
    @(posedge CLK); #1;
    resetn = 1;
    @(posedge CLK); #1;
    do_search(1, 0);
    // Zero-vector candidate SAD=10 against (0,0) candidate SAD=1.
    fill_const(100, 200);
    for (int r = 0; r < BLK; r++) for (int j = 0; j < BLK; j++) begin
      can_m[0][r][j] = 100;
      can_m[N_STEP/2][r][N_PE/2+j] = 100;
    end
    can_m[0][0][0] = 101;
    can_m[N_STEP/2][1][N_PE/2+2] = 110;
    do_search(0, 0);
    for (int t = 0; t < 4; t++) begin
      fill_rand();
      do_search(2, 0);
    end
    repeat (2) @(posedge CLK);
    chk("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/me_sad_engine.md
Name: me_sad_engine

Overview:
- Parametrised successor to the fixed 8-MAD motion-estimation datapath: one block computes N_PE horizontal candidate SADs in parallel per vertical step, sweeps N_STEP vertical steps, and tracks the running minimum internally.
- Sits between the search-range memory and current-block buffer (upstream) and the vector consumer (downstream).
- Valid/ready handshakes replace fixed controller timing.

Parameters:
- PIX_W, 8: pixel width in bits.
- BLK, 4: block width and height in pixels.
- N_PE, 8: horizontal candidate offsets evaluated in parallel (dx = 0..N_PE-1).
- N_STEP, 8: vertical candidate offsets (dy = 0..N_STEP-1).
- SAD_W, 21: SAD accumulator width; must be at least PIX_W + 2*clog2(BLK).
- ZMV_BIAS, 16: zero-vector bias; used only with ME_ZMV_BIAS_EN.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin a new block search; honoured only in IDLE.
- cur_row  in  BLK*PIX_W  current-block row; pixel 0 in the LSBs.
- cur_valid  in  1  cur_row valid.
- cur_ready  out  1  high in LOAD_CUR.
- can_row  in  (BLK+N_PE-1)*PIX_W  candidate window row; pixel 0 in the LSBs.
- can_valid  in  1  can_row valid.
- can_ready  out  1  high in SEARCH.
- vec_valid  out  1  result valid.
- vec_ready  in  1  result accepted.
- vec_x  out  VEC_W (clog2(max(N_PE,N_STEP))+1)  signed dx - N_PE/2.
- vec_y  out  VEC_W  signed dy - N_STEP/2.
- best_sad  out  SAD_W  unbiased SAD of the winning candidate.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active low):
  - State goes to IDLE.
  - All outputs go to 0; accumulators and best registers go to 0.
- States and transitions:
  - IDLE -> LOAD_CUR on start.
  - LOAD_CUR -> SEARCH after BLK beats of cur_valid & cur_ready. Rows are stored in order 0..BLK-1.
  - SEARCH -> FLUSH after N_STEP*BLK beats of can_valid & can_ready. Beat k is row (k mod BLK) of step dy = k div BLK.
  - FLUSH -> DONE after 2 cycles.
  - DONE -> IDLE on vec_valid & vec_ready.
- Datapath per accepted candidate beat, row r:
  - For each PE p: acc[p] += sum over i of |cur[r][i] - can_row[p+i]|.
  - Unsigned arithmetic, no overflow given the SAD_W rule.
  - If SAD_W is set too small, saturate at all-ones.
- Pipeline:
  - On the beat with r = BLK-1, the completed acc[] is copied into a compare register and acc[] clears. Back-to-back steps therefore need no bubble.
  - Next cycle: a min-tree picks the lowest SAD, choosing the lowest p on ties.
  - It replaces best only if strictly less than best, or if this is the first step. Ties keep the earlier (lower dy, then lower dx) candidate.
- Latency:
  - vec_valid rises on the 3rd rising edge after the final candidate handshake edge (the 2 FLUSH cycles plus the DONE entry edge).
  - vec_x, vec_y and best_sad are stable from that point until the handshake.
- can_ready is constantly 1 during SEARCH; source stalls (can_valid low) are allowed anywhere.
- In DONE, vec_valid stays high while vec_ready is low and all outputs hold.
- start outside IDLE is ignored; an in-flight search is never aborted except by reset.
- Asserting resetn low mid-operation discards all partial sums. A following start behaves exactly as a start after power-up.
- cur_row and can_row are ignored when their ready is low.

Optional Feature:
- Macro: ME_ZMV_BIAS_EN.
- When defined:
  - The candidate with dx = N_PE/2 and dy = N_STEP/2 is compared using max(SAD - ZMV_BIAS, 0).
  - best_sad still reports the raw unbiased SAD of the winner; extra raw-SAD storage is required.
- When undefined: all candidates are compared with their raw SAD, and no bias logic is synthesised.

Test Plan:
- All tests use the defaults BLK=4, N_PE=8, N_STEP=8.
1. Reset with resetn=0 mid-stream -> all outputs 0, busy=0, cur_ready=can_ready=0; the next search completes correctly.
2. Exact match at dx=3, dy=5, all other candidates off by 10 per pixel -> vec_x=-1, vec_y=+1, best_sad=0; vec_valid rises 3 edges after the last beat.
3. Uniform offset of 10 per pixel for every candidate (all SAD=160) -> tie rule gives vec_x=-4, vec_y=-4, best_sad=160.
4. cur all 0, candidates all 255 -> best_sad=4080, vec (-4,-4), no saturation. Repeat with random can_valid stalls and confirm an identical result.
5. vec_ready held low 5 cycles with start pulsed in DONE -> outputs stable, start ignored; on vec_ready=1, IDLE the next cycle, busy=0.
6. With ME_ZMV_BIAS_EN: centre SAD=10, dx=0/dy=0 SAD=0 -> winner is the centre (biased value 0, earlier index wins tie? no: (0,0) is earlier, so set its SAD=1) -> vec (0,0), best_sad=10. Without the macro -> vec (-4,-4), best_sad=1.
